// File: rtl/drr_req_issuer_if.sv
// Signal bundle between drr_req_issuer and its surroundings: descriptor source, weight config,
// DRR calc engine, PIFO dequeue feedback and the downstream rank sink.
interface drr_req_issuer_if #(
    parameter int CLASS_WIDTH         = 5,
    parameter int WEIGHT_WIDTH        = 16,
    parameter int PKT_WIDTH           = 16,
    parameter int TAG_WIDTH           = 8,
    parameter int RESULT_WIDTH        = 32,
    parameter int PIFO_OVERFLOW_WIDTH = 1,
    parameter int PIFO_ROUND_WIDTH    = 18
);
    logic                           pkt_valid;
    logic                           pkt_ready;
    logic [CLASS_WIDTH-1:0]         pkt_class_id;
    logic [PKT_WIDTH-1:0]           pkt_len;
    logic [TAG_WIDTH-1:0]           pkt_tag;

    logic                           cfg_wr_en;
    logic [CLASS_WIDTH-1:0]         cfg_class_id;
    logic [WEIGHT_WIDTH-1:0]        cfg_weight;

    logic                           req_valid;
    logic [CLASS_WIDTH-1:0]         req_class_id;
    logic [WEIGHT_WIDTH-1:0]        req_class_weight;
    logic [WEIGHT_WIDTH-1:0]        req_div_quotient;
    logic [WEIGHT_WIDTH-1:0]        req_div_remain;

    logic                           resp_valid;
    logic [RESULT_WIDTH-1:0]        resp_data;

    logic                           deq_valid;
    logic [RESULT_WIDTH-1:0]        deq_rank;
    logic                           last_pifo_valid;
    logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow;
    logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round;

    logic                           out_valid;
    logic                           out_ready;
    logic [TAG_WIDTH-1:0]           out_tag;
    logic [RESULT_WIDTH-1:0]        out_rank;

    logic                           err_timeout;

    modport master (
        input  pkt_valid, pkt_class_id, pkt_len, pkt_tag,
        input  cfg_wr_en, cfg_class_id, cfg_weight,
        input  resp_valid, resp_data, deq_valid, deq_rank, out_ready,
        output pkt_ready, req_valid, req_class_id, req_class_weight,
        output req_div_quotient, req_div_remain,
        output last_pifo_valid, last_pifo_overflow, last_pifo_round,
        output out_valid, out_tag, out_rank, err_timeout
    );

    modport slave (
        output pkt_valid, pkt_class_id, pkt_len, pkt_tag,
        output cfg_wr_en, cfg_class_id, cfg_weight,
        output resp_valid, resp_data, deq_valid, deq_rank, out_ready,
        input  pkt_ready, req_valid, req_class_id, req_class_weight,
        input  req_div_quotient, req_div_remain,
        input  last_pifo_valid, last_pifo_overflow, last_pifo_round,
        input  out_valid, out_tag, out_rank, err_timeout
    );
endinterface

// File: rtl/drr_req_issuer.sv
// DRR rank request issuer: weight lookup, sequential length/weight division, single outstanding
// request to the calc engine with response timeout, and last-dequeued PIFO round tracking.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | pkt_ready=1, waiting for a descriptor
// S_DIVIDE    | restoring divider, one quotient bit per cycle
// S_ISSUE     | one-cycle request pulse to the engine
// S_WAIT_RESP | waiting for the engine response, timeout down-counter running
// S_OUTPUT    | holding {tag, rank} until the sink takes it
module drr_req_issuer #(
    parameter int CLASS_WIDTH         = 5,
    parameter int WEIGHT_WIDTH        = 16,
    parameter int PKT_WIDTH           = 16,
    parameter int TAG_WIDTH           = 8,
    parameter int RESULT_WIDTH        = 32,
    parameter int PIFO_OVERFLOW_WIDTH = 1,
    parameter int PIFO_ROUND_WIDTH    = 18,
    parameter int PIFO_ADDR_WIDTH     = 12,
    parameter int RESP_TIMEOUT        = 64
) (
    input  logic             clk,
    input  logic             rst,
    drr_req_issuer_if.master bus
);
    localparam int DEPTH     = 2 ** CLASS_WIDTH;
    localparam int DIV_CNT_W = $clog2(PKT_WIDTH + 1);
    localparam int TMO_CNT_W = $clog2(RESP_TIMEOUT + 1);
    localparam int ROUND_LSB = PIFO_ADDR_WIDTH;
    localparam int OVF_LSB   = PIFO_ADDR_WIDTH + PIFO_ROUND_WIDTH;
    localparam int OVF_MSB   = OVF_LSB + PIFO_OVERFLOW_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIVIDE,
        S_ISSUE,
        S_WAIT_RESP,
        S_OUTPUT
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [WEIGHT_WIDTH-1:0]   weight_tbl [DEPTH];
    logic [WEIGHT_WIDTH-1:0]   lookup_w;

    logic [CLASS_WIDTH-1:0]    cls_q;
    logic [WEIGHT_WIDTH-1:0]   weight_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic [PKT_WIDTH-1:0]      dvd_q;
    logic [WEIGHT_WIDTH-1:0]   rem_q;
    logic [DIV_CNT_W-1:0]      div_cnt_q;
    logic [TMO_CNT_W-1:0]      tmo_cnt_q;
    logic [RESULT_WIDTH-1:0]   rank_q;

    logic [WEIGHT_WIDTH:0]     trial;
    logic                      trial_ge;

    logic                      accept;
    logic                      div_step;
    logic                      resp_take;
    logic                      in_issue;
    logic                      in_output;

    logic [PIFO_OVERFLOW_WIDTH-1:0] ovf_q;
    logic [PIFO_ROUND_WIDTH-1:0]    round_q;
    logic                           lpv_q;
    logic                           unused_deq;

    // Table read happens before this cycle's cfg write lands, so a same-cycle write is not seen.
    assign lookup_w = weight_tbl[bus.pkt_class_id];

    // dvd_q shifts the dividend out of its top and the quotient bits in at the bottom.
    assign trial    = {rem_q, dvd_q[PKT_WIDTH-1]};
    assign trial_ge = (trial >= {1'b0, weight_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        div_step        = 1'b0;
        resp_take       = 1'b0;
        bus.pkt_ready   = 1'b0;
        bus.req_valid   = 1'b0;
        bus.out_valid   = 1'b0;
        bus.err_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                bus.pkt_ready = 1'b1;
                if (bus.pkt_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                div_step = 1'b1;
                if (div_cnt_q == '0) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.req_valid = 1'b1;
                state_nxt     = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (bus.resp_valid) begin
                    resp_take = 1'b1;
                    state_nxt = S_OUTPUT;
                end else if (tmo_cnt_q == '0) begin
                    bus.err_timeout = 1'b1;
                    state_nxt       = S_IDLE;
                end
            end
            S_OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                weight_tbl[i] <= '0;
            end
            cls_q     <= '0;
            weight_q  <= '0;
            tag_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            div_cnt_q <= '0;
            tmo_cnt_q <= '0;
            rank_q    <= '0;
        end else begin
            if (bus.cfg_wr_en) begin
                weight_tbl[bus.cfg_class_id] <= bus.cfg_weight;
            end

            if (accept) begin
                cls_q     <= bus.pkt_class_id;
                tag_q     <= bus.pkt_tag;
                weight_q  <= (lookup_w == '0) ? WEIGHT_WIDTH'(1) : lookup_w;
                dvd_q     <= bus.pkt_len;
                rem_q     <= '0;
                div_cnt_q <= DIV_CNT_W'(PKT_WIDTH - 1);
            end else if (div_step) begin
                rem_q     <= trial_ge ? WEIGHT_WIDTH'(trial - {1'b0, weight_q})
                                      : trial[WEIGHT_WIDTH-1:0];
                dvd_q     <= {dvd_q[PKT_WIDTH-2:0], trial_ge};
                div_cnt_q <= div_cnt_q - 1'b1;
            end

            if (in_issue) begin
                tmo_cnt_q <= TMO_CNT_W'(RESP_TIMEOUT - 1);
            end else if (state == S_WAIT_RESP) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end

            if (resp_take) begin
                rank_q <= bus.resp_data;
            end
        end
    end

    // Dequeue feedback runs regardless of the request FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            lpv_q   <= 1'b0;
            ovf_q   <= '0;
            round_q <= '0;
        end else if (bus.deq_valid) begin
            lpv_q   <= 1'b1;
            ovf_q   <= bus.deq_rank[OVF_MSB:OVF_LSB];
            round_q <= bus.deq_rank[ROUND_LSB +: PIFO_ROUND_WIDTH];
        end
    end

    assign unused_deq = ^{bus.deq_rank[PIFO_ADDR_WIDTH-1:0],
                          bus.deq_rank[RESULT_WIDTH-1:OVF_MSB+1]};

    assign in_issue  = (state == S_ISSUE);
    assign in_output = (state == S_OUTPUT);

    // Request and output payloads read zero whenever their valid is low.
    assign bus.req_class_id     = in_issue ? cls_q : '0;
    assign bus.req_class_weight = in_issue ? weight_q : '0;
    assign bus.req_div_quotient = in_issue ? WEIGHT_WIDTH'(dvd_q) : '0;
    assign bus.req_div_remain   = in_issue ? rem_q : '0;

    assign bus.out_tag  = in_output ? tag_q : '0;
    assign bus.out_rank = in_output ? rank_q : '0;

    assign bus.last_pifo_valid    = lpv_q;
    assign bus.last_pifo_overflow = ovf_q;
    assign bus.last_pifo_round    = round_q;
endmodule

// File: tb/tb_drr_req_issuer.sv
// Randomized self-checking bench for drr_req_issuer; expectations come from a weight-table
// model and integer division/modulo on each descriptor.
module tb_drr_req_issuer;
    localparam int PKT_WIDTH    = 16;
    localparam int RESP_TIMEOUT = 64;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   wt [32];

    drr_req_issuer_if bus ();

    drr_req_issuer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_round(input logic [31:0] r);
        return 64'((r >> 12) & 32'h0003_FFFF);
    endfunction

    function automatic logic [63:0] exp_ovf(input logic [31:0] r);
        return 64'((r >> 30) & 32'h1);
    endfunction

    function automatic logic any_out();
        return |{bus.req_valid, bus.req_class_id, bus.req_class_weight, bus.req_div_quotient,
                 bus.req_div_remain, bus.last_pifo_valid, bus.last_pifo_overflow,
                 bus.last_pifo_round, bus.out_valid, bus.out_tag, bus.out_rank, bus.err_timeout};
    endfunction

    task automatic cfg_write(input logic [4:0] cls, input int w);
        bus.cfg_wr_en    = 1'b1;
        bus.cfg_class_id = cls;
        bus.cfg_weight   = 16'(w);
        tick();
        bus.cfg_wr_en = 1'b0;
        wt[cls] = w;
    endtask

    task automatic deq_check(input string name, input logic [31:0] r);
        chk({name, "_lpv"}, 64'(bus.last_pifo_valid), 64'(1));
        chk({name, "_ovf"}, 64'(bus.last_pifo_overflow), exp_ovf(r));
        chk({name, "_round"}, 64'(bus.last_pifo_round), exp_round(r));
    endtask

    task automatic deq_burst(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r             = $urandom;
            bus.deq_valid = 1'b1;
            bus.deq_rank  = r;
            tick();
            deq_check("deq_burst", r);
        end
        bus.deq_valid = 1'b0;
    endtask

    // d == 0: engine never answers. same_w / mid_w < 0: no cfg write at accept / during divide.
    task automatic run_pkt(input logic [4:0] cls, input logic [15:0] len, input logic [7:0] tag,
                           input int d, input logic [31:0] resp, input int stall,
                           input int same_w, input int mid_w, input bit junk, input bit do_deq);
        int          w;
        int          exp_q;
        int          exp_r;
        int          cyc;
        int          n;
        bit          busy_ok;
        bit          stable_ok;
        bit          out_seen;
        logic [31:0] dr;
        w     = (wt[cls] == 0) ? 1 : wt[cls];
        exp_q = int'(len) / w;
        exp_r = int'(len) % w;
        dr    = $urandom;

        bus.pkt_valid    = 1'b1;
        bus.pkt_class_id = cls;
        bus.pkt_len      = len;
        bus.pkt_tag      = tag;
        bus.out_ready    = (stall == 0);
        if (same_w >= 0) begin
            bus.cfg_wr_en    = 1'b1;
            bus.cfg_class_id = cls;
            bus.cfg_weight   = 16'(same_w);
        end
        chk("accept_ready", 64'(bus.pkt_ready), 64'(1));
        tick();
        bus.pkt_valid = 1'b0;
        bus.cfg_wr_en = 1'b0;
        if (same_w >= 0) wt[cls] = same_w;

        cyc     = 1;
        busy_ok = 1'b1;
        while (!bus.req_valid && cyc < 100) begin
            if (bus.pkt_ready) busy_ok = 1'b0;
            if (do_deq && cyc == 3) deq_check("deq_in_flight", dr);
            bus.deq_valid = (do_deq && cyc == 2);
            bus.deq_rank  = dr;
            if (mid_w >= 0 && cyc == 4) begin
                bus.cfg_wr_en    = 1'b1;
                bus.cfg_class_id = cls;
                bus.cfg_weight   = 16'(mid_w);
                wt[cls]          = mid_w;
            end else begin
                bus.cfg_wr_en = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.cfg_wr_en = 1'b0;
        bus.deq_valid = 1'b0;

        chk("req_latency", 64'(cyc), 64'(PKT_WIDTH + 1));
        chk("busy_not_ready", 64'(busy_ok), 64'(1));
        chk("req_class", 64'(bus.req_class_id), 64'(cls));
        chk("req_weight", 64'(bus.req_class_weight), 64'(w));
        chk("req_quotient", 64'(bus.req_div_quotient), 64'(exp_q & 32'hFFFF));
        chk("req_remain", 64'(bus.req_div_remain), 64'(exp_r));

        if (junk) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = ~resp;
        end
        tick();
        bus.resp_valid = 1'b0;
        cyc = 1;
        chk("req_one_cycle", 64'(bus.req_valid), 64'(0));

        if (d == 0) begin
            out_seen = 1'b0;
            while (!bus.err_timeout && cyc < 200) begin
                if (bus.out_valid) out_seen = 1'b1;
                tick();
                cyc++;
            end
            chk("timeout_cycle", 64'(cyc), 64'(RESP_TIMEOUT));
            chk("timeout_no_out", 64'(out_seen | bus.out_valid), 64'(0));
            tick();
            chk("timeout_pulse", 64'(bus.err_timeout), 64'(0));
            chk("timeout_ready", 64'(bus.pkt_ready), 64'(1));
            bus.out_ready = 1'b1;
            return;
        end

        while (cyc < d) begin
            tick();
            cyc++;
        end
        bus.resp_valid = 1'b1;
        bus.resp_data  = resp;
        tick();
        bus.resp_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("out_latency", 64'(PKT_WIDTH + 2 + d + n), 64'(PKT_WIDTH + 2 + d));
        chk("out_tag", 64'(bus.out_tag), 64'(tag));
        chk("out_rank", 64'(bus.out_rank), 64'(resp));
        chk("no_err", 64'(bus.err_timeout), 64'(0));

        stable_ok = 1'b1;
        busy_ok   = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = $urandom;
            end
            tick();
            if (!bus.out_valid || bus.out_tag != tag || bus.out_rank != resp) stable_ok = 1'b0;
            if (bus.pkt_ready) busy_ok = 1'b0;
        end
        bus.resp_valid = 1'b0;
        if (stall > 0) begin
            chk("stall_stable", 64'(stable_ok), 64'(1));
            chk("stall_not_ready", 64'(busy_ok), 64'(1));
        end
        bus.out_ready = 1'b1;
        tick();
        chk("out_done", 64'(bus.out_valid), 64'(0));
        chk("idle_ready", 64'(bus.pkt_ready), 64'(1));
    endtask

    initial begin
        int          seen;
        logic [4:0]  c;
        int          d;
        int          w;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) wt[i] = 0;
        rst              = 1'b1;
        bus.pkt_valid    = 1'b0;
        bus.pkt_class_id = '0;
        bus.pkt_len      = '0;
        bus.pkt_tag      = '0;
        bus.cfg_wr_en    = 1'b0;
        bus.cfg_class_id = '0;
        bus.cfg_weight   = '0;
        bus.resp_valid   = 1'b0;
        bus.resp_data    = '0;
        bus.deq_valid    = 1'b0;
        bus.deq_rank     = '0;
        bus.out_ready    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", 64'(bus.pkt_ready), 64'(1));
        chk("rst_outputs_zero", 64'(any_out()), 64'(0));

        cfg_write(5'd3, 100);
        run_pkt(5'd3, 16'd1550, 8'h21, 3, 32'h8000_5000, 0, -1, -1, 1'b0, 1'b0);
        run_pkt(5'd0, 16'd7, 8'h07, 3, 32'h1234_5678, 0, -1, -1, 1'b1, 1'b0);
        run_pkt(5'd3, 16'd999, 8'h5A, 0, 32'h0, 0, -1, -1, 1'b0, 1'b0);
        run_pkt(5'd3, 16'd250, 8'hA5, 5, 32'hCAFE_0001, 10, -1, -1, 1'b1, 1'b0);
        run_pkt(5'd3, 16'd65535, 8'h3C, 1, 32'hFFFF_FFFF, 0, -1, -1, 1'b0, 1'b0);

        cfg_write(5'd5, 100);
        run_pkt(5'd5, 16'd400, 8'h55, 3, 32'h0000_0400, 0, 200, -1, 1'b0, 1'b0);
        run_pkt(5'd5, 16'd400, 8'h56, 2, 32'h0000_0200, 0, -1, 7, 1'b0, 1'b1);
        run_pkt(5'd5, 16'd400, 8'h57, 2, 32'h0000_0057, 0, -1, -1, 1'b0, 1'b0);

        bus.deq_valid = 1'b1;
        bus.deq_rank  = 32'h8001_2000;
        tick();
        bus.deq_valid = 1'b0;
        deq_check("deq_directed", 32'h8001_2000);
        chk("deq_round_value", 64'(bus.last_pifo_round), 64'h12);
        tick();
        chk("deq_sticky", 64'(bus.last_pifo_valid), 64'(1));
        deq_burst(4);

        bus.pkt_valid    = 1'b1;
        bus.pkt_class_id = 5'd3;
        bus.pkt_len      = 16'd1000;
        bus.pkt_tag      = 8'hEE;
        tick();
        bus.pkt_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) wt[i] = 0;
        chk("mid_rst_ready", 64'(bus.pkt_ready), 64'(1));
        chk("mid_rst_zero", 64'(any_out()), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.req_valid || bus.out_valid) seen = 1;
            tick();
        end
        chk("mid_rst_no_req", 64'(seen), 64'(0));
        run_pkt(5'd3, 16'd1000, 8'hEF, 4, 32'h0BAD_F00D, 0, -1, -1, 1'b0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = 5'($urandom_range(0, 7));
                w = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 600));
                cfg_write(c, w);
            end
            c = 5'($urandom_range(0, 7));
            d = (it % 8 == 7) ? 0 : int'($urandom_range(1, 20));
            run_pkt(c, 16'($urandom), 8'($urandom), d, $urandom,
                    int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 900)) : -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 900)) : -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
